// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command stage in front of the sr_ff set/reset flip-flop.
// Synchronises and debounces two raw request lines, resolves same-cycle conflicts and
// issues clean, registered, mutually exclusive s/r pulses followed by an optional holdoff.
//
// Ports:
//   clk      - system clock, rising-edge
//   rst      - asynchronous active-low reset
//   set_in   - raw asynchronous set request
//   clr_in   - raw asynchronous clear request
//   s        - registered set pulse to sr_ff.s
//   r        - registered reset pulse to sr_ff.r
//   busy     - registered, high during a pulse or holdoff
//   conflict - registered one-cycle flag: set and clear events landed together
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_LEN  = 1,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned CW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PMAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  localparam logic [CW-1:0] DebLast   = CW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PulseLoad = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0] HoldLoad  = (HOLDOFF > 0) ? PW'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {StIdle, StSetP, StClrP, StHold} state_e;

  // Channel 0 = set, channel 1 = clear.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, filt_d;
  logic [1:0]    evt_q, evt_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          conflict_d;
  logic          s_q, r_q, busy_q, conflict_q;

  assign raw = {clr_in, set_in};

  // Debounce: the filtered level only follows the synchronised input after DEB_CYCLES
  // consecutive mismatching edges; an event fires only on a 0->1 filtered transition.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]  = '0;
      filt_d[i] = filt_q[i];
      evt_d[i]  = 1'b0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          filt_d[i] = sync2_q[i];
          evt_d[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      evt_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command FSM; events seen outside StIdle are dropped, never queued.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    conflict_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (evt_q[0] && evt_q[1]) begin
          conflict_d = 1'b1;
        end else if (evt_q[0]) begin
          state_d = StSetP;
          pcnt_d  = PulseLoad;
        end else if (evt_q[1]) begin
          state_d = StClrP;
          pcnt_d  = PulseLoad;
        end
      end
      StSetP, StClrP: begin
        if (pcnt_q == '0) begin
          if (HOLDOFF == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
            pcnt_d  = HoldLoad;
          end
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      StHold: begin
        if (pcnt_q == '0) begin
          state_d = StIdle;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      s_q        <= (state_d == StSetP);
      r_q        <= (state_d == StClrP);
      busy_q     <= (state_d != StIdle);
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule
